// File: rtl/spi_byte_rx.sv
// spi_byte_rx: receive-only SPI mode-0 byte engine for the PmodJSTK frame path.
//   CLK      system clock, rising edge
//   RST      synchronous reset, active-high
//   getByte  transfer request, accepted only while idle
//   MISO     serial data from the slave, assumed synchronous to CLK
//   SCLK     SPI clock, idles low
//   BUSY     high for the whole transfer including the inter-byte gap
//   RxData   last completed byte, held between transfers
//   rxValid  one-cycle pulse when RxData updates
module spi_byte_rx #(
    parameter int HALF_PERIOD = 1,
    parameter int GAP_CYCLES  = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       getByte,
    input  logic       MISO,
    output logic       SCLK,
    output logic       BUSY,
    output logic [7:0] RxData,
    output logic       rxValid
);
    localparam int DW = $clog2(HALF_PERIOD + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {Idle, Lead, High, Low, Gap, Done} stateT;

    stateT         state;
    logic [7:0]    shiftReg;
    logic [3:0]    bitCnt;
    logic [DW-1:0] div;
    logic [GW-1:0] gapCnt;
    logic          divLast;

    assign divLast = (div == DIV_LAST);

    // Done is the cycle in which the byte is presented; it already accepts a
    // new request so that back-to-back transfers are separated by one idle cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= Idle;
            SCLK     <= 1'b0;
            BUSY     <= 1'b0;
            RxData   <= 8'h00;
            rxValid  <= 1'b0;
            shiftReg <= 8'h00;
            bitCnt   <= 4'd0;
            div      <= '0;
            gapCnt   <= '0;
        end else begin
            rxValid <= 1'b0;
            case (state)
                Idle, Done: begin
                    state <= getByte ? Lead : Idle;
                    if (getByte) begin
                        BUSY   <= 1'b1;
                        div    <= '0;
                        bitCnt <= 4'd0;
                    end
                end
                Lead, Low: begin
                    if (!divLast) begin
                        div <= div + 1'b1;
                    end else if (state == Lead || bitCnt < 4'd8) begin
                        // SCLK rises on this edge; MISO was set up on the previous fall
                        state    <= High;
                        SCLK     <= 1'b1;
                        div      <= '0;
                        shiftReg <= {shiftReg[6:0], MISO};
                        bitCnt   <= bitCnt + 4'd1;
                    end else if (GAP_CYCLES > 0) begin
                        state  <= Gap;
                        gapCnt <= '0;
                    end else begin
                        state   <= Done;
                        BUSY    <= 1'b0;
                        rxValid <= 1'b1;
                        RxData  <= shiftReg;
                    end
                end
                High: begin
                    if (!divLast) begin
                        div <= div + 1'b1;
                    end else begin
                        state <= Low;
                        SCLK  <= 1'b0;
                        div   <= '0;
                    end
                end
                Gap: begin
                    if (gapCnt != GAP_LAST) begin
                        gapCnt <= gapCnt + 1'b1;
                    end else begin
                        state   <= Done;
                        BUSY    <= 1'b0;
                        rxValid <= 1'b1;
                        RxData  <= shiftReg;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_byte_rx.sv
// tb_spi_byte_rx: directed self-checking bench for spi_byte_rx with two parameter sets.
module tb_spi_byte_rx;
    logic       clk = 1'b0;
    logic       rst1, get1, miso1, sclk1, busy1, valid1;
    logic [7:0] rx1;
    logic       rst3, get3, miso3, sclk3, busy3, valid3;
    logic [7:0] rx3;
    int         checks = 0;
    int         failures = 0;

    // slave models: a 16-bit word shifted out MSB-first, advancing on each SCLK fall
    int          falls1 = 0, base1 = 0, falls3 = 0, base3 = 0;
    logic [15:0] word1 = 16'h0, word3 = 16'h0;

    always #5 clk = ~clk;

    spi_byte_rx #(.HALF_PERIOD(1), .GAP_CYCLES(0)) dut1 (
        .CLK(clk), .RST(rst1), .getByte(get1), .MISO(miso1),
        .SCLK(sclk1), .BUSY(busy1), .RxData(rx1), .rxValid(valid1)
    );

    spi_byte_rx #(.HALF_PERIOD(3), .GAP_CYCLES(5)) dut3 (
        .CLK(clk), .RST(rst3), .getByte(get3), .MISO(miso3),
        .SCLK(sclk3), .BUSY(busy3), .RxData(rx3), .rxValid(valid3)
    );

    always @(negedge sclk1) falls1++;
    always @(negedge sclk3) falls3++;

    always_comb begin
        int k;
        k = falls1 - base1;
        miso1 = (k >= 0 && k < 16) ? word1[4'(15 - k)] : 1'b0;
    end

    always_comb begin
        int k;
        k = falls3 - base3;
        miso3 = (k >= 0 && k < 16) ? word3[4'(15 - k)] : 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [15:0] w);
        base1 = falls1;
        word1 = w;
    endtask

    task automatic load3(input logic [15:0] w);
        base3 = falls3;
        word3 = w;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; get1 = 1'b1; rst3 = 1'b1; get3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({sclk1, busy1, rx1, valid1} !== 11'h0) begin
                failures++;
                $display("FAIL reset_dut1 cycle %0d: sclk=%b busy=%b rx=%h valid=%b, expected all 0", i, sclk1, busy1, rx1, valid1);
            end
            checks++;
            if ({sclk3, busy3, rx3, valid3} !== 11'h0) begin
                failures++;
                $display("FAIL reset_dut3 cycle %0d: sclk=%b busy=%b rx=%h valid=%b, expected all 0", i, sclk3, busy3, rx3, valid3);
            end
        end
        get1 = 1'b0; get3 = 1'b0; rst1 = 1'b0; rst3 = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int   rises = 0, firstRise = -1, busyBad = 0;
        logic prevS = 1'b0;
        load1(16'hA500);
        get1 = 1'b1;
        tick();
        get1 = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            if (sclk1 && !prevS) begin
                rises++;
                if (firstRise < 0) firstRise = e;
            end
            prevS = sclk1;
            if (e <= 17 && busy1 !== 1'b1) busyBad++;
            if (e == 18) begin
                checks++;
                if (busy1 !== 1'b0) begin failures++; $display("FAIL single_busy_fall: busy=%b at edge 18, expected 0", busy1); end
                checks++;
                if (rx1 !== 8'hA5) begin failures++; $display("FAIL single_data: rx=%h, expected a5", rx1); end
                checks++;
                if (valid1 !== 1'b1) begin failures++; $display("FAIL single_valid: valid=%b at edge 18, expected 1", valid1); end
            end
            if (e == 19) begin
                checks++;
                if (valid1 !== 1'b0) begin failures++; $display("FAIL single_valid_width: valid=%b at edge 19, expected 0", valid1); end
            end
            tick();
        end
        checks++;
        if (busyBad != 0) begin failures++; $display("FAIL single_busy_high: %0d edges of 1..17 without busy, expected 0", busyBad); end
        checks++;
        if (rises != 8) begin failures++; $display("FAIL single_rises: %0d sclk rises, expected 8", rises); end
        checks++;
        if (firstRise != 2) begin failures++; $display("FAIL single_first_rise: first rise at edge %0d, expected 2", firstRise); end
    endtask

    task automatic test_back_to_back();
        int         busyRises = 0, pulses = 0, lowRun = 0, gapLen = -1;
        logic       prevB = 1'b0;
        logic [7:0] d0 = 8'h00, d1 = 8'h00;
        load1(16'h3CFF);
        get1 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (busy1 && !prevB) begin
                busyRises++;
                if (busyRises == 2) begin
                    gapLen = lowRun;
                    get1 = 1'b0;
                end
            end
            prevB = busy1;
            lowRun = busy1 ? 0 : lowRun + 1;
            if (valid1) begin
                if (pulses == 0) d0 = rx1; else d1 = rx1;
                pulses++;
            end
        end
        get1 = 1'b0;
        checks++;
        if (pulses != 2) begin failures++; $display("FAIL b2b_pulses: %0d rxValid pulses, expected 2", pulses); end
        checks++;
        if (d0 !== 8'h3C) begin failures++; $display("FAIL b2b_first: rx=%h, expected 3c", d0); end
        checks++;
        if (d1 !== 8'hFF) begin failures++; $display("FAIL b2b_second: rx=%h, expected ff", d1); end
        checks++;
        if (gapLen != 1) begin failures++; $display("FAIL b2b_gap: busy low %0d cycles, expected 1", gapLen); end
    endtask

    task automatic test_reset_mid();
        int   rises = 0, stray = 0;
        logic prevS = 1'b0;
        logic seen = 1'b0;
        load1(16'hF000);
        get1 = 1'b1;
        tick();
        get1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (sclk1 && !prevS) rises++;
            prevS = sclk1;
            if (rises == 4) break;
            tick();
        end
        checks++;
        if (rises != 4) begin failures++; $display("FAIL mid_reach_rise4: saw %0d rises, expected 4", rises); end
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        checks++;
        if (sclk1 !== 1'b0) begin failures++; $display("FAIL mid_sclk: sclk=%b, expected 0", sclk1); end
        checks++;
        if (busy1 !== 1'b0) begin failures++; $display("FAIL mid_busy: busy=%b, expected 0", busy1); end
        checks++;
        if (rx1 !== 8'h00) begin failures++; $display("FAIL mid_rx: rx=%h, expected 00", rx1); end
        checks++;
        if (valid1 !== 1'b0) begin failures++; $display("FAIL mid_valid: valid=%b, expected 0", valid1); end
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid1 || busy1) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL mid_no_resume: %0d cycles with busy/valid, expected 0", stray); end
        load1(16'h5A00);
        get1 = 1'b1;
        tick();
        get1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid1) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL mid_retry_valid: no rxValid within 40 cycles, expected one"); end
        checks++;
        if (rx1 !== 8'h5A) begin failures++; $display("FAIL mid_retry_data: rx=%h, expected 5a", rx1); end
    endtask

    task automatic test_request_during_busy();
        int busyCnt = 0, pulses = 0;
        load1(16'h9600);
        get1 = 1'b1;
        tick();
        get1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy1) busyCnt++;
            if (valid1) pulses++;
            get1 = busy1 && busyCnt == 6;
            tick();
        end
        get1 = 1'b0;
        checks++;
        if (busyCnt != 17) begin failures++; $display("FAIL busy_req_len: busy %0d cycles, expected 17", busyCnt); end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL busy_req_pulses: %0d rxValid pulses, expected 1", pulses); end
        checks++;
        if (rx1 !== 8'h96) begin failures++; $display("FAIL busy_req_data: rx=%h, expected 96", rx1); end
    endtask

    task automatic test_slow_gap();
        int   busyCnt = 0, rises = 0, highRun = 0, badRun = 0, pulses = 0;
        logic prevS = 1'b0;
        load3(16'h8100);
        get3 = 1'b1;
        tick();
        get3 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (busy3) busyCnt++;
            if (valid3) pulses++;
            if (sclk3) begin
                highRun++;
            end else begin
                if (prevS && highRun != 3) badRun++;
                highRun = 0;
            end
            if (sclk3 && !prevS) rises++;
            prevS = sclk3;
            tick();
        end
        checks++;
        if (busyCnt != 56) begin failures++; $display("FAIL slow_busy_len: busy %0d cycles, expected 56", busyCnt); end
        checks++;
        if (rises != 8) begin failures++; $display("FAIL slow_rises: %0d sclk rises, expected 8", rises); end
        checks++;
        if (badRun != 0) begin failures++; $display("FAIL slow_high_width: %0d high phases not 3 cycles, expected 0", badRun); end
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL slow_pulses: %0d rxValid pulses, expected 1", pulses); end
        checks++;
        if (rx3 !== 8'h81) begin failures++; $display("FAIL slow_data: rx=%h, expected 81", rx3); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_request_during_busy();
        test_slow_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
